// File: rtl/brick_game_sequencer.sv
// Game-state owner for the brick-breaker datapath: holds ball, paddle and brick map,
// commits the physics step on each frame tick, and tracks lives, score and speed-up.
module brick_game_sequencer #(
  parameter logic [1439:0] BRICK_INIT       = {1440{1'b1}},
  parameter int            LIVES            = 3,
  parameter int            VX0              = 3,
  parameter int            VY0              = 2,
  parameter int            VMAX             = 8,
  parameter int            HITS_PER_SPEEDUP = 8,
  parameter int            BOARD_STEP       = 6,
  parameter int            MISS_Y           = 470
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_tick,
  input  logic            btn_launch,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic [1439:0]   next_bricks,
  input  logic [9:0]      next_ball_x,
  input  logic [9:0]      next_ball_y,
  input  logic [9:0]      next_ball_vx,
  input  logic [9:0]      next_ball_vy,
  input  logic [1:0]      next_ball_dir,
  input  logic            collision_trig,
  output logic [1439:0]   bricks,
  output logic [9:0]      ball_x,
  output logic [9:0]      ball_y,
  output logic [9:0]      ball_vx,
  output logic [9:0]      ball_vy,
  output logic [1:0]      ball_dir,
  output logic [9:0]      board_x,
  output logic [2:0]      state,
  output logic [1:0]      lives,
  output logic [15:0]     score,
  output logic            hit_pulse,
  output logic            game_over
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_OVER  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  localparam logic [9:0] C_VX0       = 10'(VX0);
  localparam logic [9:0] C_VY0       = 10'(VY0);
  localparam logic [9:0] C_VMAX      = 10'(VMAX);
  localparam logic [9:0] C_STEP      = 10'(BOARD_STEP);
  localparam logic [9:0] C_MISS_Y    = 10'(MISS_Y);
  localparam logic [9:0] C_BOARD_MAX = 10'd544;
  localparam logic [9:0] C_BOARD_RST = 10'd272;
  localparam logic [9:0] C_GLUE_DX   = 10'd40;
  localparam logic [9:0] C_GLUE_Y    = 10'd456;
  localparam logic [1:0] C_LIVES     = 2'(LIVES);
  localparam logic [7:0] C_HITS      = 8'(HITS_PER_SPEEDUP);
  localparam logic [1:0] C_DIR_SERVE = 2'b10;

  logic [1439:0] r_bricks;
  logic [9:0]    r_ball_x, r_ball_y, r_ball_vx, r_ball_vy, r_board_x;
  logic [1:0]    r_ball_dir, r_lives;
  logic [2:0]    r_state;
  logic [15:0]   r_score;
  logic [7:0]    r_hits;
  logic          r_hit_pulse;
  logic          r_launch_d;

  logic          w_launch_edge;
  logic [9:0]    w_board_next;
  logic [9:0]    w_vx_up, w_vy_up;
  logic [7:0]    w_hits_inc;
  logic          w_brick_frame;
  logic          w_speedup;

  assign w_launch_edge = btn_launch & ~r_launch_d;
  assign w_brick_frame = (next_bricks != r_bricks);
  assign w_hits_inc    = r_hits + 8'd1;
  assign w_speedup     = w_brick_frame && (w_hits_inc == C_HITS);
  assign w_vx_up       = (r_ball_vx >= C_VMAX) ? C_VMAX : r_ball_vx + 10'd1;
  assign w_vy_up       = (r_ball_vy >= C_VMAX) ? C_VMAX : r_ball_vy + 10'd1;

  // Pressing both directions cancels out, matching the "neither" case.
  always_comb begin
    w_board_next = r_board_x;
    if (btn_left && !btn_right)
      w_board_next = (r_board_x > C_STEP) ? r_board_x - C_STEP : 10'd0;
    else if (btn_right && !btn_left)
      w_board_next = (r_board_x + C_STEP > C_BOARD_MAX) ? C_BOARD_MAX : r_board_x + C_STEP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bricks    <= BRICK_INIT;
      r_board_x   <= C_BOARD_RST;
      r_ball_x    <= C_BOARD_RST + C_GLUE_DX;
      r_ball_y    <= C_GLUE_Y;
      r_ball_vx   <= C_VX0;
      r_ball_vy   <= C_VY0;
      r_ball_dir  <= C_DIR_SERVE;
      r_lives     <= C_LIVES;
      r_score     <= 16'd0;
      r_hits      <= 8'd0;
      r_hit_pulse <= 1'b0;
      r_launch_d  <= 1'b1;
    end else begin
      r_launch_d  <= btn_launch;
      r_hit_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch_edge) r_state <= S_SERVE;
        end
        S_SERVE: begin
          if (frame_tick) begin
            r_board_x <= w_board_next;
            r_ball_x  <= w_board_next + C_GLUE_DX;
            r_ball_y  <= C_GLUE_Y;
          end
          if (w_launch_edge) begin
            r_state    <= S_PLAY;
            r_ball_dir <= C_DIR_SERVE;
            r_ball_vx  <= C_VX0;
            r_ball_vy  <= C_VY0;
            r_hits     <= 8'd0;
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            r_board_x   <= w_board_next;
            r_ball_x    <= next_ball_x;
            r_ball_y    <= next_ball_y;
            r_ball_dir  <= next_ball_dir;
            r_bricks    <= next_bricks;
            r_hit_pulse <= collision_trig;
            r_ball_vx   <= w_speedup ? w_vx_up : next_ball_vx;
            r_ball_vy   <= w_speedup ? w_vy_up : next_ball_vy;
            if (w_brick_frame) begin
              r_score <= (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
              r_hits  <= w_speedup ? 8'd0 : w_hits_inc;
            end
            // A cleared board wins over a simultaneous miss and costs no life.
            if (next_bricks == '0) begin
              r_state <= S_CLEAR;
            end else if (next_ball_y >= C_MISS_Y) begin
              r_lives <= r_lives - 2'd1;
              if (r_lives == 2'd1) begin
                r_state <= S_OVER;
              end else begin
                r_state    <= S_SERVE;
                r_ball_vx  <= C_VX0;
                r_ball_vy  <= C_VY0;
                r_ball_dir <= C_DIR_SERVE;
              end
            end
          end
        end
        S_OVER: begin
          if (w_launch_edge) begin
            r_bricks <= BRICK_INIT;
            r_lives  <= C_LIVES;
            r_score  <= 16'd0;
            r_state  <= S_SERVE;
          end
        end
        S_CLEAR: begin
          if (w_launch_edge) begin
            r_bricks <= BRICK_INIT;
            r_state  <= S_SERVE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bricks    = r_bricks;
  assign ball_x    = r_ball_x;
  assign ball_y    = r_ball_y;
  assign ball_vx   = r_ball_vx;
  assign ball_vy   = r_ball_vy;
  assign ball_dir  = r_ball_dir;
  assign board_x   = r_board_x;
  assign state     = r_state;
  assign lives     = r_lives;
  assign score     = r_score;
  assign hit_pulse = r_hit_pulse;
  assign game_over = (r_state == S_OVER);

endmodule

// File: tb/tb_brick_game_sequencer.sv
// Scoreboard bench for brick_game_sequencer: a small game model pushes expected
// snapshots as stimulus is driven; each scenario pops and compares after the edge.
module tb_brick_game_sequencer;

  localparam logic [1439:0] INIT = {1440{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, frame_tick, btn_launch, btn_left, btn_right, collision_trig;
  logic [1439:0] next_bricks, bricks;
  logic [9:0]    next_ball_x, next_ball_y, next_ball_vx, next_ball_vy;
  logic [9:0]    ball_x, ball_y, ball_vx, ball_vy, board_x;
  logic [1:0]    next_ball_dir, ball_dir, lives;
  logic [2:0]    state;
  logic [15:0]   score;
  logic          hit_pulse, game_over;

  brick_game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_launch(btn_launch),
    .btn_left(btn_left), .btn_right(btn_right), .next_bricks(next_bricks),
    .next_ball_x(next_ball_x), .next_ball_y(next_ball_y), .next_ball_vx(next_ball_vx),
    .next_ball_vy(next_ball_vy), .next_ball_dir(next_ball_dir), .collision_trig(collision_trig),
    .bricks(bricks), .ball_x(ball_x), .ball_y(ball_y), .ball_vx(ball_vx), .ball_vy(ball_vy),
    .ball_dir(ball_dir), .board_x(board_x), .state(state), .lives(lives), .score(score),
    .hit_pulse(hit_pulse), .game_over(game_over)
  );

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  lv;
    logic [15:0] sc;
    logic [9:0]  bx, x, y, vx, vy;
    logic [1:0]  dir;
    logic        hp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_checks = 0;
  int n_pass   = 0;

  int m_state, m_board, m_x, m_y, m_vx, m_vy, m_dir, m_lives, m_score, m_hits, m_hp;
  logic [1439:0] m_bricks, pat_a, pat_b;

  function automatic exp_t snap();
    exp_t s;
    s.st = 3'(m_state); s.lv = 2'(m_lives); s.sc = 16'(m_score);
    s.bx = 10'(m_board); s.x = 10'(m_x); s.y = 10'(m_y);
    s.vx = 10'(m_vx); s.vy = 10'(m_vy); s.dir = 2'(m_dir); s.hp = 1'(m_hp);
    return s;
  endfunction

  function automatic int paddle(input int b, input logic l, input logic r);
    if (l && !r) return (b - 6 < 0) ? 0 : b - 6;
    if (r && !l) return (b + 6 > 544) ? 544 : b + 6;
    return b;
  endfunction

  function automatic int sat8(input int v);
    return (v >= 8) ? 8 : v + 1;
  endfunction

  task automatic drive(input logic tick, input logic launch, input logic left, input logic right);
    frame_tick = tick; btn_launch = launch; btn_left = left; btn_right = right;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_board = 272; m_x = 312; m_y = 456; m_vx = 3; m_vy = 2; m_dir = 2;
    m_lives = 3; m_score = 0; m_hits = 0; m_hp = 0; m_bricks = INIT;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    model_reset();
    sb.push_back(snap());
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (state !== e.st) $display("FAIL reset_state: got %0d want %0d", state, e.st); else n_pass++;
    n_checks++; if (board_x !== e.bx) $display("FAIL reset_board: got %0d want %0d", board_x, e.bx); else n_pass++;
    n_checks++; if (ball_x !== e.x) $display("FAIL reset_ball_x: got %0d want %0d", ball_x, e.x); else n_pass++;
    n_checks++; if (ball_y !== e.y) $display("FAIL reset_ball_y: got %0d want %0d", ball_y, e.y); else n_pass++;
    n_checks++; if (ball_vx !== e.vx) $display("FAIL reset_vx: got %0d want %0d", ball_vx, e.vx); else n_pass++;
    n_checks++; if (ball_vy !== e.vy) $display("FAIL reset_vy: got %0d want %0d", ball_vy, e.vy); else n_pass++;
    n_checks++; if (ball_dir !== e.dir) $display("FAIL reset_dir: got %0d want %0d", ball_dir, e.dir); else n_pass++;
    n_checks++; if (lives !== e.lv) $display("FAIL reset_lives: got %0d want %0d", lives, e.lv); else n_pass++;
    n_checks++; if (score !== e.sc) $display("FAIL reset_score: got %0d want %0d", score, e.sc); else n_pass++;
    n_checks++; if (hit_pulse !== e.hp) $display("FAIL reset_hit_pulse: got %0d want %0d", hit_pulse, e.hp); else n_pass++;
    n_checks++; if (bricks !== m_bricks) $display("FAIL reset_bricks: got init=%0d want init=1", bricks == INIT); else n_pass++;
    n_checks++; if (game_over !== 1'b0) $display("FAIL reset_game_over: got %0d want 0", game_over); else n_pass++;
    sb.push_back(snap());
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (state !== e.st) $display("FAIL idle_after_release: got %0d want %0d", state, e.st); else n_pass++;
    m_state = 1;
    sb.push_back(snap());
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (state !== e.st) $display("FAIL idle_to_serve: got %0d want %0d", state, e.st); else n_pass++;
    n_checks++; if (board_x !== e.bx) $display("FAIL idle_tick_board: got %0d want %0d", board_x, e.bx); else n_pass++;
  endtask

  task automatic test_paddle();
    for (int i = 0; i < 50; i++) begin
      m_board = paddle(m_board, 1'b0, 1'b1); m_x = m_board + 40; m_y = 456;
      sb.push_back(snap());
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      e = sb.pop_front();
      n_checks++; if (board_x !== e.bx) $display("FAIL paddle_right[%0d]: got %0d want %0d", i, board_x, e.bx); else n_pass++;
      n_checks++; if (ball_x !== e.x) $display("FAIL glue_x_right[%0d]: got %0d want %0d", i, ball_x, e.x); else n_pass++;
    end
    n_checks++; if (board_x !== 10'd544) $display("FAIL paddle_ceiling: got %0d want 544", board_x); else n_pass++;
    n_checks++; if (ball_x !== 10'd584) $display("FAIL glue_ceiling: got %0d want 584", ball_x); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(snap());
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      e = sb.pop_front();
      n_checks++; if (board_x !== e.bx) $display("FAIL paddle_both[%0d]: got %0d want %0d", i, board_x, e.bx); else n_pass++;
    end
    m_board = 200;
    for (int i = 0; i < 95; i++) begin
      m_board = (i == 0) ? paddle(544, 1'b1, 1'b0) : paddle(m_board, 1'b1, 1'b0);
      m_x = m_board + 40;
      sb.push_back(snap());
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      n_checks++; if (board_x !== e.bx) $display("FAIL paddle_left[%0d]: got %0d want %0d", i, board_x, e.bx); else n_pass++;
    end
    n_checks++; if (board_x !== 10'd0) $display("FAIL paddle_floor: got %0d want 0", board_x); else n_pass++;
    n_checks++; if (ball_x !== 10'd40) $display("FAIL glue_floor: got %0d want 40", ball_x); else n_pass++;
    sb.push_back(snap());
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++; if (board_x !== e.bx) $display("FAIL paddle_no_tick: got %0d want %0d", board_x, e.bx); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      m_board = paddle(m_board, 1'b0, 1'b1); m_x = m_board + 40;
      sb.push_back(snap());
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      e = sb.pop_front();
      n_checks++; if (ball_x !== e.x) $display("FAIL glue_x_back[%0d]: got %0d want %0d", i, ball_x, e.x); else n_pass++;
    end
  endtask

  task automatic test_launch_play();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    m_board = paddle(m_board, 1'b0, 1'b1); m_x = m_board + 40;
    m_state = 2; m_dir = 2; m_vx = 3; m_vy = 2; m_hits = 0;
    sb.push_back(snap());
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++; if (state !== e.st) $display("FAIL launch_state: got %0d want %0d", state, e.st); else n_pass++;
    n_checks++; if (board_x !== e.bx) $display("FAIL launch_tick_board: got %0d want %0d", board_x, e.bx); else n_pass++;
    n_checks++; if (ball_x !== e.x) $display("FAIL launch_tick_glue: got %0d want %0d", ball_x, e.x); else n_pass++;
    n_checks++; if (ball_dir !== e.dir) $display("FAIL launch_dir: got %0d want %0d", ball_dir, e.dir); else n_pass++;
    n_checks++; if (ball_vx !== e.vx || ball_vy !== e.vy)
      $display("FAIL launch_speed: got %0d/%0d want %0d/%0d", ball_vx, ball_vy, e.vx, e.vy); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_speedup();
    for (int k = 1; k <= 56; k++) begin
      next_bricks = k[0] ? pat_a : pat_b;
      next_ball_x = 10'(100 + k); next_ball_y = 10'd200; next_ball_dir = 2'b11;
      next_ball_vx = 10'(m_vx); next_ball_vy = 10'(m_vy); collision_trig = k[0];
      m_bricks = next_bricks; m_score++; m_hits++;
      if (m_hits == 8) begin m_hits = 0; m_vx = sat8(m_vx); m_vy = sat8(m_vy); end
      m_x = 100 + k; m_y = 200; m_dir = 3; m_hp = k[0] ? 1 : 0;
      sb.push_back(snap());
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++; if (score !== e.sc) $display("FAIL brick_score[%0d]: got %0d want %0d", k, score, e.sc); else n_pass++;
      n_checks++; if (ball_vx !== e.vx || ball_vy !== e.vy)
        $display("FAIL speedup[%0d]: got %0d/%0d want %0d/%0d", k, ball_vx, ball_vy, e.vx, e.vy); else n_pass++;
      n_checks++; if (hit_pulse !== e.hp) $display("FAIL hit_pulse_rise[%0d]: got %0d want %0d", k, hit_pulse, e.hp); else n_pass++;
      n_checks++; if (ball_x !== e.x) $display("FAIL commit_x[%0d]: got %0d want %0d", k, ball_x, e.x); else n_pass++;
      if (k == 8) begin
        n_checks++; if (ball_vx !== 10'd4 || ball_vy !== 10'd3 || score !== 16'd8)
          $display("FAIL eighth_hit: got vx=%0d vy=%0d score=%0d want 4/3/8", ball_vx, ball_vy, score); else n_pass++;
      end
      m_hp = 0;
      sb.push_back(snap());
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++; if (hit_pulse !== e.hp) $display("FAIL hit_pulse_fall[%0d]: got %0d want %0d", k, hit_pulse, e.hp); else n_pass++;
    end
    n_checks++; if (ball_vx !== 10'd8 || ball_vy !== 10'd8)
      $display("FAIL speed_cap: got %0d/%0d want 8/8", ball_vx, ball_vy); else n_pass++;
    n_checks++; if (bricks !== m_bricks) $display("FAIL bricks_commit: got patb=%0d want 1", bricks == pat_b); else n_pass++;
    n_checks++; if (ball_dir !== 2'b11) $display("FAIL dir_commit: got %0d want 3", ball_dir); else n_pass++;
    next_bricks = m_bricks; collision_trig = 1'b0;
    next_ball_vx = 10'(m_vx); next_ball_vy = 10'(m_vy);
    sb.push_back(snap());
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (score !== e.sc) $display("FAIL non_brick_frame: got %0d want %0d", score, e.sc); else n_pass++;
    n_checks++; if (hit_pulse !== e.hp) $display("FAIL no_collision_pulse: got %0d want %0d", hit_pulse, e.hp); else n_pass++;
  endtask

  task automatic test_miss();
    next_bricks = m_bricks; collision_trig = 1'b0;
    next_ball_y = 10'd469;
    m_y = 469;
    sb.push_back(snap());
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (state !== e.st || lives !== e.lv)
      $display("FAIL miss_below: got st=%0d lives=%0d want %0d/%0d", state, lives, e.st, e.lv); else n_pass++;
    next_ball_y = 10'd470;
    m_y = 470; m_lives = 2; m_state = 1; m_vx = 3; m_vy = 2; m_dir = 2;
    sb.push_back(snap());
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (state !== e.st) $display("FAIL miss_state: got %0d want %0d", state, e.st); else n_pass++;
    n_checks++; if (lives !== e.lv) $display("FAIL miss_lives: got %0d want %0d", lives, e.lv); else n_pass++;
    n_checks++; if (ball_vx !== e.vx || ball_vy !== e.vy || ball_dir !== e.dir)
      $display("FAIL miss_reload: got %0d/%0d/%0d want %0d/%0d/%0d", ball_vx, ball_vy, ball_dir, e.vx, e.vy, e.dir); else n_pass++;
    n_checks++; if (score !== e.sc) $display("FAIL miss_score: got %0d want %0d", score, e.sc); else n_pass++;
    next_ball_vx = 10'd3; next_ball_vy = 10'd2; next_ball_y = 10'd471;
    for (int r = 0; r < 2; r++) begin
      m_state = 2; m_hits = 0;
      sb.push_back(snap());
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++; if (state !== e.st) $display("FAIL relaunch[%0d]: got %0d want %0d", r, state, e.st); else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      m_lives--; m_y = 471; m_state = (m_lives == 0) ? 3 : 1;
      sb.push_back(snap());
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++; if (state !== e.st || lives !== e.lv)
        $display("FAIL miss_again[%0d]: got st=%0d lives=%0d want %0d/%0d", r, state, lives, e.st, e.lv); else n_pass++;
    end
    n_checks++; if (game_over !== 1'b1) $display("FAIL game_over_set: got %0d want 1", game_over); else n_pass++;
    next_bricks = pat_a;
    sb.push_back(snap());
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++; if (state !== e.st || board_x !== e.bx || score !== e.sc)
      $display("FAIL over_tick_frozen: got st=%0d bx=%0d sc=%0d want %0d/%0d/%0d", state, board_x, score, e.st, e.bx, e.sc); else n_pass++;
    n_checks++; if (bricks !== m_bricks) $display("FAIL over_tick_bricks: got same=%0d want 1", bricks == m_bricks); else n_pass++;
    m_state = 1; m_lives = 3; m_score = 0; m_bricks = INIT;
    sb.push_back(snap());
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (state !== e.st || lives !== e.lv || score !== e.sc)
      $display("FAIL over_restart: got st=%0d lv=%0d sc=%0d want %0d/%0d/%0d", state, lives, score, e.st, e.lv, e.sc); else n_pass++;
    n_checks++; if (bricks !== m_bricks) $display("FAIL over_reload: got init=%0d want 1", bricks == INIT); else n_pass++;
    n_checks++; if (game_over !== 1'b0) $display("FAIL game_over_clear: got %0d want 0", game_over); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    m_state = 2; m_hits = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    next_bricks = '0; next_ball_y = 10'd475;
    m_board = paddle(m_board, 1'b0, 1'b1); m_state = 4; m_score = 1; m_bricks = '0;
    sb.push_back(snap());
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++; if (state !== e.st) $display("FAIL clear_state: got %0d want %0d", state, e.st); else n_pass++;
    n_checks++; if (lives !== e.lv) $display("FAIL clear_lives: got %0d want %0d", lives, e.lv); else n_pass++;
    n_checks++; if (score !== e.sc) $display("FAIL clear_score: got %0d want %0d", score, e.sc); else n_pass++;
    n_checks++; if (board_x !== e.bx) $display("FAIL clear_board: got %0d want %0d", board_x, e.bx); else n_pass++;
    n_checks++; if (bricks !== m_bricks) $display("FAIL clear_bricks: got zero=%0d want 1", bricks == '0); else n_pass++;
    next_bricks = pat_a; next_ball_y = 10'd200;
    sb.push_back(snap());
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++; if (state !== e.st || board_x !== e.bx)
      $display("FAIL clear_tick_frozen: got st=%0d bx=%0d want %0d/%0d", state, board_x, e.st, e.bx); else n_pass++;
    m_state = 1; m_bricks = INIT;
    sb.push_back(snap());
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (state !== e.st || score !== e.sc || lives !== e.lv)
      $display("FAIL clear_restart: got st=%0d sc=%0d lv=%0d want %0d/%0d/%0d", state, score, lives, e.st, e.sc, e.lv); else n_pass++;
    n_checks++; if (bricks !== m_bricks) $display("FAIL clear_reload: got init=%0d want 1", bricks == INIT); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midplay();
    m_state = 2;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    next_bricks = pat_a; collision_trig = 1'b1; next_ball_y = 10'd200;
    m_score = 2; m_hp = 1;
    sb.push_back(snap());
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++; if (hit_pulse !== e.hp || score !== e.sc)
      $display("FAIL pre_reset_play: got hp=%0d sc=%0d want %0d/%0d", hit_pulse, score, e.hp, e.sc); else n_pass++;
    rst_n = 1'b0; next_bricks = pat_b;
    model_reset();
    sb.push_back(snap());
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    e = sb.pop_front();
    n_checks++; if (state !== e.st || lives !== e.lv || score !== e.sc)
      $display("FAIL midreset_counts: got st=%0d lv=%0d sc=%0d want %0d/%0d/%0d", state, lives, score, e.st, e.lv, e.sc); else n_pass++;
    n_checks++; if (board_x !== e.bx || ball_x !== e.x || ball_y !== e.y)
      $display("FAIL midreset_pos: got %0d/%0d/%0d want %0d/%0d/%0d", board_x, ball_x, ball_y, e.bx, e.x, e.y); else n_pass++;
    n_checks++; if (ball_vx !== e.vx || ball_vy !== e.vy || ball_dir !== e.dir)
      $display("FAIL midreset_vel: got %0d/%0d/%0d want %0d/%0d/%0d", ball_vx, ball_vy, ball_dir, e.vx, e.vy, e.dir); else n_pass++;
    n_checks++; if (hit_pulse !== e.hp) $display("FAIL midreset_hit_pulse: got %0d want %0d", hit_pulse, e.hp); else n_pass++;
    n_checks++; if (bricks !== m_bricks) $display("FAIL midreset_bricks: got init=%0d want 1", bricks == INIT); else n_pass++;
    sb.push_back(snap());
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++; if (state !== e.st || hit_pulse !== e.hp || board_x !== e.bx)
      $display("FAIL post_reset_idle: got st=%0d hp=%0d bx=%0d want %0d/%0d/%0d", state, hit_pulse, board_x, e.st, e.hp, e.bx); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; btn_launch = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
    collision_trig = 1'b0; next_bricks = INIT;
    next_ball_x = 10'd0; next_ball_y = 10'd0; next_ball_vx = 10'd3; next_ball_vy = 10'd2;
    next_ball_dir = 2'b10;
    pat_a = INIT; pat_a[0] = 1'b0;
    pat_b = INIT; pat_b[1] = 1'b0;
    model_reset();
    test_reset();
    test_paddle();
    test_launch_play();
    test_speedup();
    test_miss();
    test_clear();
    test_reset_midplay();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
